// File: rtl/zero_detect_pipe_if.sv
// Operand/result handshake bundle for zero_detect_pipe.
// master = producer/consumer side, slave = the detector itself.
interface zero_detect_pipe_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] in_cmp;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic             out_match;
    logic             out_neg;

    modport master (
        output in_valid, in_data, in_cmp, in_mode, out_ready,
        input  in_ready, out_valid, out_match, out_neg
    );

    modport slave (
        input  in_valid, in_data, in_cmp, in_mode, out_ready,
        output in_ready, out_valid, out_match, out_neg
    );
endinterface

// File: rtl/zero_detect_pipe.sv
// Pipelined zero / all-ones / equality / masked-zero detector with valid/ready flow control.
// Optional saturating match counter enabled by ZERO_DETECT_MATCH_COUNT_EN.
module zero_detect_pipe #(
    parameter int unsigned WIDTH            = 64,
    parameter int unsigned LEVELS_PER_STAGE = 2,
    parameter int unsigned CNT_W            = 16
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef ZERO_DETECT_MATCH_COUNT_EN
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] match_count,
`endif
    zero_detect_pipe_if.slave bus
);
    localparam int unsigned L = $clog2(WIDTH);
    localparam int unsigned P = 1 << L;
    localparam int unsigned S = (L + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

    logic [P-1:0] w_t;
    logic         w_out_valid;
    logic         w_out_match;
    logic         w_out_neg;

    always_comb begin
        w_t = '0;
        unique case (bus.in_mode)
            2'd0: w_t[WIDTH-1:0] = bus.in_data;
            2'd1: w_t[WIDTH-1:0] = ~bus.in_data;
            2'd2: w_t[WIDTH-1:0] = bus.in_data ^ bus.in_cmp;
            2'd3: w_t[WIDTH-1:0] = bus.in_data & bus.in_cmp;
        endcase
    end

    for (genvar s = 0; s < S; s++) begin : g_stage
        localparam int unsigned LV_LO = s * LEVELS_PER_STAGE;
        localparam int unsigned LV_HI = ((s + 1) * LEVELS_PER_STAGE < L) ?
                                        (s + 1) * LEVELS_PER_STAGE : L;
        localparam int unsigned NL    = LV_HI - LV_LO;
        localparam int unsigned WIN   = P >> LV_LO;
        localparam int unsigned WOUT  = P >> LV_HI;

        logic [WIN-1:0]  w_in;
        logic [WOUT-1:0] w_or;
        logic [WOUT-1:0] r_data;
        logic            r_valid;
        logic            r_neg;
        logic            w_up_valid;
        logic            w_up_neg;
        logic            w_dn_ld;
        logic            w_ld;

        if (s == 0) begin : g_src
            assign w_in       = w_t;
            assign w_up_valid = bus.in_valid;
            assign w_up_neg   = bus.in_data[WIDTH-1];
        end else begin : g_src
            assign w_in       = g_stage[s-1].r_data;
            assign w_up_valid = g_stage[s-1].r_valid;
            assign w_up_neg   = g_stage[s-1].r_neg;
        end

        // A stage may load when empty or when its contents move on this edge,
        // which lets bubbles collapse and keeps full-rate flow-through.
        if (s == S - 1) begin : g_dn
            assign w_dn_ld = bus.out_ready;
        end else begin : g_dn
            assign w_dn_ld = g_stage[s+1].w_ld;
        end
        assign w_ld = ~r_valid | w_dn_ld;

        for (genvar k = 0; k <= NL; k++) begin : g_lvl
            logic [(WIN >> k)-1:0] w_v;
            if (k == 0) begin : g_root
                assign w_v = w_in;
            end else begin : g_pair
                for (genvar j = 0; j < (WIN >> k); j++) begin : g_or
                    assign w_v[j] = g_lvl[k-1].w_v[2*j] | g_lvl[k-1].w_v[2*j+1];
                end
            end
        end
        assign w_or = g_lvl[NL].w_v;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_valid <= 1'b0;
            end else if (w_ld) begin
                r_valid <= w_up_valid;
            end
        end

        // Final stage stores the inverted OR, i.e. the match flag itself.
        always_ff @(posedge clk) begin
            if (w_ld) begin
                r_neg  <= w_up_neg;
                r_data <= (s == S - 1) ? ~w_or : w_or;
            end
        end
    end

    assign w_out_valid   = g_stage[S-1].r_valid;
    assign w_out_match   = w_out_valid & g_stage[S-1].r_data[0];
    assign w_out_neg     = w_out_valid & g_stage[S-1].r_neg;

    assign bus.in_ready  = g_stage[0].w_ld;
    assign bus.out_valid = w_out_valid;
    assign bus.out_match = w_out_match;
    assign bus.out_neg   = w_out_neg;

`ifdef ZERO_DETECT_MATCH_COUNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_out_match && bus.out_ready && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign match_count = r_cnt;
`else
    // CNT_W stays a legal override target even without the counter.
    if (CNT_W == 0) begin : g_no_counter
    end
`endif
endmodule

// File: tb/tb_zero_detect_pipe.sv
// Directed self-checking bench for zero_detect_pipe (64-bit/S=3 and 37-bit/S=2 instances).
// Counter checks run only when ZERO_DETECT_MATCH_COUNT_EN is defined.
module tb_zero_detect_pipe;
    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    int unsigned n_vec   = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    zero_detect_pipe_if #(.WIDTH(64)) b64 ();
    zero_detect_pipe_if #(.WIDTH(37)) b37 ();

`ifdef ZERO_DETECT_MATCH_COUNT_EN
    logic        cnt_clr   = 1'b0;
    logic [1:0]  match_count;
    logic        cnt_clr37 = 1'b0;
    logic [15:0] match_count37;
`endif

    zero_detect_pipe #(.WIDTH(64), .LEVELS_PER_STAGE(2), .CNT_W(2)) u_dut64 (
        .clk         (clk),
        .reset_n     (reset_n),
`ifdef ZERO_DETECT_MATCH_COUNT_EN
        .cnt_clr     (cnt_clr),
        .match_count (match_count),
`endif
        .bus         (b64)
    );

    zero_detect_pipe #(.WIDTH(37), .LEVELS_PER_STAGE(4), .CNT_W(16)) u_dut37 (
        .clk         (clk),
        .reset_n     (reset_n),
`ifdef ZERO_DETECT_MATCH_COUNT_EN
        .cnt_clr     (cnt_clr37),
        .match_count (match_count37),
`endif
        .bus         (b37)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operand through the 3-stage pipe with out_ready=1.
    task automatic run64(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] mode, input logic exp_m, input logic exp_n);
        b64.in_data  = a;
        b64.in_cmp   = b;
        b64.in_mode  = mode;
        b64.in_valid = 1'b1;
        check({tag, "/in_ready"}, b64.in_ready, 1);
        tick();
        b64.in_valid = 1'b0;
        tick();
        check({tag, "/early"}, b64.out_valid, 0);
        tick();
        check({tag, "/valid"}, b64.out_valid, 1);
        check({tag, "/match"}, b64.out_match, exp_m);
        check({tag, "/neg"},   b64.out_neg,   exp_n);
        tick();
    endtask

    task automatic run37(input string tag, input logic [36:0] a, input logic [1:0] mode,
                         input logic exp_m, input logic exp_n);
        b37.in_data  = a;
        b37.in_cmp   = '0;
        b37.in_mode  = mode;
        b37.in_valid = 1'b1;
        tick();
        b37.in_valid = 1'b0;
        check({tag, "/early"}, b37.out_valid, 0);
        tick();
        check({tag, "/valid"}, b37.out_valid, 1);
        check({tag, "/match"}, b37.out_match, exp_m);
        check({tag, "/neg"},   b37.out_neg,   exp_n);
        tick();
    endtask

    initial begin
        b64.in_valid = 1'b0; b64.in_data = '0; b64.in_cmp = '0; b64.in_mode = 2'd0;
        b64.out_ready = 1'b1;
        b37.in_valid = 1'b0; b37.in_data = '0; b37.in_cmp = '0; b37.in_mode = 2'd0;
        b37.out_ready = 1'b1;

        #2 reset_n = 1'b0;
        tick();
        tick();
        check("rst/out_valid", b64.out_valid, 0);
        check("rst/out_match", b64.out_match, 0);
        check("rst/out_neg",   b64.out_neg,   0);
        check("rst/in_ready",  b64.in_ready,  1);
        check("rst/out_valid37", b37.out_valid, 0);
        #3 reset_n = 1'b1;
        tick();

        run64("m0 zero",   64'h0,                   64'h0, 2'd0, 1'b1, 1'b0);
        run64("m0 msb",    64'h8000_0000_0000_0000, 64'h0, 2'd0, 1'b0, 1'b1);
        run64("m0 lsb",    64'h0000_0000_0000_0001, 64'h0, 2'd0, 1'b0, 1'b0);
        run64("m1 ones",   64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 2'd1, 1'b1, 1'b1);
        run64("m1 fffe",   64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 2'd1, 1'b0, 1'b1);
        run64("m2 eq",     64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 2'd2, 1'b1, 1'b0);
        run64("m2 ne",     64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF1, 2'd2, 1'b0, 1'b0);
        run64("m3 disj",   64'hF0, 64'h0F, 2'd3, 1'b1, 1'b0);
        run64("m3 ovl",    64'hF0, 64'h10, 2'd3, 1'b0, 1'b0);

        // Stall and ordering: operands 0,1,0,2,0 in mode 0 -> matches 1,0,1,0,1.
        b64.out_ready = 1'b0;
        b64.in_mode   = 2'd0;
        b64.in_cmp    = '0;
        b64.in_valid  = 1'b1;
        b64.in_data   = 64'd0;
        check("stall/acc0", b64.in_ready, 1);
        tick();
        b64.in_data = 64'd1;
        check("stall/acc1", b64.in_ready, 1);
        tick();
        b64.in_data = 64'd0;
        check("stall/acc2", b64.in_ready, 1);
        tick();
        b64.in_data = 64'd2;
        check("stall/full_ready", b64.in_ready,  0);
        check("stall/full_valid", b64.out_valid, 1);
        check("stall/full_match", b64.out_match, 1);
        tick();
        check("stall/hold1_ready", b64.in_ready,  0);
        check("stall/hold1_match", b64.out_match, 1);
        tick();
        check("stall/hold2_valid", b64.out_valid, 1);
        check("stall/hold2_match", b64.out_match, 1);
        b64.out_ready = 1'b1;
        #1;
        check("stall/flow_ready", b64.in_ready, 1);
        tick();
        check("order/r1_valid", b64.out_valid, 1);
        check("order/r1_match", b64.out_match, 0);
        b64.in_data = 64'd0;
        check("order/acc4", b64.in_ready, 1);
        tick();
        b64.in_valid = 1'b0;
        check("order/r2_match", b64.out_match, 1);
        tick();
        check("order/r3_valid", b64.out_valid, 1);
        check("order/r3_match", b64.out_match, 0);
        tick();
        check("order/r4_valid", b64.out_valid, 1);
        check("order/r4_match", b64.out_match, 1);
        tick();
        check("order/drained", b64.out_valid, 0);

        // Mid-flight reset with a result at the output and one behind it.
        b64.in_mode  = 2'd1;
        b64.in_data  = '1;
        b64.in_valid = 1'b1;
        tick();
        tick();
        b64.in_valid = 1'b0;
        tick();
        check("mfr/pre_valid", b64.out_valid, 1);
        check("mfr/pre_match", b64.out_match, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mfr/async_valid", b64.out_valid, 0);
        check("mfr/async_match", b64.out_match, 0);
        check("mfr/async_neg",   b64.out_neg,   0);
        tick();
        #3 reset_n = 1'b1;
        tick();
        check("mfr/idle1", b64.out_valid, 0);
        tick();
        check("mfr/idle2", b64.out_valid, 0);
        tick();
        check("mfr/idle3", b64.out_valid, 0);
        run64("mfr new", 64'h0, 64'h0, 2'd0, 1'b1, 1'b0);

`ifdef ZERO_DETECT_MATCH_COUNT_EN
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("cnt/cleared", match_count, 0);
        b64.in_mode  = 2'd0;
        b64.in_data  = '0;
        b64.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        b64.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("cnt/saturated", match_count, 3);
        b64.in_valid = 1'b1;
        tick();
        b64.in_valid = 1'b0;
        tick();
        tick();
        check("cnt/coinc_valid", b64.out_valid, 1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("cnt/clr_priority", match_count, 0);
        run64("cnt inc", 64'h0, 64'h0, 2'd0, 1'b1, 1'b0);
        check("cnt/one", match_count, 1);
`endif

        run37("w37 m1 ones",  37'h1F_FFFF_FFFF, 2'd1, 1'b1, 1'b1);
        run37("w37 m1 b36",   37'h0F_FFFF_FFFF, 2'd1, 1'b0, 1'b0);
        run37("w37 m0 zero",  37'h0,            2'd0, 1'b1, 1'b0);
        run37("w37 m0 b36",   37'h10_0000_0000, 2'd0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/zero_detect_pipe.md
Name: zero_detect_pipe

Overview:
- Parametrised, pipelined successor to the combinational 64-bit zero checker.
- Reduces an arbitrary-width operand through a registered tree of 2-input OR levels, with a pipeline register every LEVELS_PER_STAGE levels.
- Supports four match modes: zero, all-ones, equality, and masked-zero.
- Sits between the execute-stage ALU and flag/branch logic; uses a valid/ready handshake so it can be stalled by downstream hazards.

Parameters:
- WIDTH, 64, operand width in bits (>= 2; need not be a power of two).
- LEVELS_PER_STAGE, 2, number of OR-reduction levels between pipeline registers (>= 1).
- CNT_W, 16, width of the optional match counter.

Ports:
- clk  in  1  clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an input this cycle.
- in_data  in  WIDTH  operand A.
- in_cmp  in  WIDTH  operand B: compare value (mode 2) or mask (mode 3); ignored in modes 0 and 1.
- in_mode  in  2  match mode: 0 zero, 1 all-ones, 2 A==B, 3 (A&B)==0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_match  out  1  mode-dependent match flag.
- out_neg  out  1  copy of in_data[WIDTH-1] for the same operand.

Behaviour:
- Transform, applied combinationally before the first level:
  - t = in_data (mode 0), ~in_data (mode 1), in_data^in_cmp (mode 2), in_data&in_cmp (mode 3).
  - t is zero-padded to P = 2^L bits, where L = ceil(log2 WIDTH).
  - match = ~|t.
- Tree structure:
  - L levels of 2-input OR.
  - Pipeline register after every LEVELS_PER_STAGE levels, plus one after the final level.
  - S = ceil(L / LEVELS_PER_STAGE) stages. WIDTH=64, LPS=2 gives L=6, S=3.
  - The final NOR inversion happens in the last stage before its register.
- Latency: a transfer accepted on edge k (in_valid & in_ready) appears with out_valid=1 after edge k+S-1, i.e. S cycles through the pipe.
- Per-stage valid bit v[i]:
  - Stage i loads when v[i]==0, or when stage i advances (i = S-1: out_ready; otherwise stage i+1 loads).
  - in_ready = stage 0 loads.
  - Bubbles collapse; no stage holds a bubble while an upstream stage is full.
- Throughput: one result per cycle when out_ready=1.
- Stall: with out_ready=0, exactly S operands can be held. in_ready falls only once all stages are full.
- Hold under stall: while out_valid=1 and out_ready=0, out_match and out_neg are held stable.
- Ordering: results leave strictly in input order; no drop or duplication.
- Flow-through: simultaneous in and out transfers on a full pipe are permitted (in_ready=1 when out_ready=1).
- Reset: reset_n=0 immediately clears all v[i], so out_valid=0, out_match=0, out_neg=0. In-flight operands are discarded. After release, the first output comes only from a new input.
- Payload registers need no reset, but the outputs must read 0 during reset.
- out_neg always reflects the raw in_data MSB, independent of mode.
- WIDTH=2 gives L=1, S=1.

Optional Feature:
- Macro: ZERO_DETECT_MATCH_COUNT_EN.
- When defined, two extra ports are added:
  - cnt_clr  in  1
  - match_count  out  CNT_W
- match_count increments by 1 on each output transfer (out_valid & out_ready) with out_match=1.
- It saturates at all-ones and does not wrap.
- cnt_clr=1 forces it to 0 on the next edge; clear has priority over a simultaneous increment.
- Reset value is 0.
- When the macro is undefined, these ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=64, LPS=2 (S=3), out_ready=1:
  - Mode 0, in_data=0 -> out_valid=1 exactly 3 cycles after acceptance, out_match=1, out_neg=0.
  - Mode 0, in_data=64'h8000_0000_0000_0000 -> out_match=0, out_neg=1.
- Mode 1: 64'hFFFF_FFFF_FFFF_FFFF -> out_match=1, out_neg=1; 64'hFFFF_FFFF_FFFF_FFFE -> out_match=0.
- Mode 2: A=B=64'h1234_5678_9ABC_DEF0 -> out_match=1. Mode 3: A=64'hF0, B=64'h0F -> out_match=1; A=64'hF0, B=64'h10 -> out_match=0.
- Stall/order: five back-to-back inputs (values 0,1,0,2,0) with out_ready=0 on cycles 1-6:
  - in_ready=0 after 3 accepted.
  - Results later emerge 1,0,1,0,1 in order, one per cycle; out_match held stable while stalled.
- Mid-flight reset: assert reset_n=0 with 2 operands in flight -> out_valid=0 asynchronously, before the next edge; after release no output appears until a new input is accepted.
- Counter (macro defined, CNT_W=2):
  - 5 matching transfers -> match_count=3 (saturated).
  - cnt_clr coincident with a matching transfer -> match_count=0.
- Non-power-of-two width: WIDTH=37, LPS=4 (L=6, S=2):
  - Mode 1 on all-ones 37 bits -> out_match=1 after 2 cycles.
  - Mode 1 with bit 36 cleared -> out_match=0.
